tpu_result_reader: RTL and testbench
====================================

// Module: tpu_result_reader
// PURPOSE
//  Read-back engine for the three result SRAMs (a, b, c) that the TPU write-out stage fills.
//  On start, reads rows 0..num_rows-1 of bank a, then bank b, then bank c (1-cycle SRAM read latency).
//  Emits each row as one beat on a valid/ready stream, tagged with bank index and last flag.
//  Sits between the result SRAMs and the host/DMA drain path; start is normally driven by tpu_done.
// PARAMETERS
//  ARRAY_SIZE         8   elements per result row
//  OUTPUT_DATA_WIDTH  16  bits per element; row width RW = ARRAY_SIZE*OUTPUT_DATA_WIDTH
//  SRAM_ADDR_WIDTH    6   result SRAM address width; max rows per bank = 2**SRAM_ADDR_WIDTH
//  BUF_DEPTH          2   output buffer entries (fixed at 2; no other value supported)
// PORTS
//  clk           in   1                  clock, all logic on rising edge
//  srstn         in   1                  asynchronous active-low reset
//  start         in   1                  1-cycle pulse; accepted only when busy==0
//  num_rows      in   SRAM_ADDR_WIDTH+1  rows per bank, sampled on accepted start; 0..2**SRAM_ADDR_WIDTH
//  sram_re_a/b/c out  1 each             read enable, at most one high per cycle
//  sram_raddr_a/b/c out SRAM_ADDR_WIDTH  read address per bank
//  sram_rdata_a/b/c in  RW each          read data, valid the cycle after re/raddr
//  out_valid     out  1                  out_data/out_bank/out_last hold a beat
//  out_ready     in   1                  consumer accepts beat when out_valid&&out_ready
//  out_data      out  RW                 result row (packed exactly as written)
//  out_bank      out  2                  0=a, 1=b, 2=c
//  out_last      out  1                  high on final beat (bank c, row num_rows-1)
//  busy          out  1                  high from accepted start until done
//  done          out  1                  1-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset: all outputs 0 (re, raddr, out_*, busy, done); FSM->IDLE; buffer empty; in-flight cleared.
//  FSM: IDLE -start-> RUN (busy=1, bank=0, row=0, rows latched) ; RUN -last read issued-> DRAIN ;
//   DRAIN -buffer empty & no in-flight-> IDLE with done=1 that cycle-edge (busy falls with done).
//  num_rows==0 on start: IDLE->DRAIN directly, no reads, no beats, done pulses 2 cycles after start.
//  start while busy: ignored, num_rows not resampled.
//  Read issue (RUN): issue when count + inflight - pop < 2, pop = out_valid&&out_ready that cycle.
//   Issue = assert re of current bank with raddr=row; row++; at row==num_rows-1 wrap row to 0, bank++.
//   Issue with bank==2, row==num_rows-1 -> RUN->DRAIN. re deasserts when not issuing; raddr holds.
//  inflight (1 bit) = issued last cycle; on following cycle capture that bank's rdata + tags into buffer.
//  Buffer: 2-entry FIFO; head drives out_*; out_valid = count!=0; capture and pop same cycle legal.
//   Credit rule guarantees no overflow; overflow condition is a design error (assert in sim).
//  Throughput: with out_ready held 1, one beat per cycle; first beat out_valid 2 cycles after start.
//  out_data/out_bank/out_last stable while out_valid && !out_ready (no change until accepted).
//  Order: a[0..N-1], b[0..N-1], c[0..N-1]; exactly 3*N beats; out_last only on beat 3N-1.
//  num_rows == 2**SRAM_ADDR_WIDTH: row counter is SRAM_ADDR_WIDTH+1 bits; raddr uses low bits; full bank read.
//  Async reset mid-operation: abort immediately, no done pulse, in-flight data discarded.
// TESTING
//  Reset mid-RUN (srstn low during bank b) -> all outputs 0 next; restart N=2 -> 6 beats from a[0], done once.
//  N=4, out_ready=1, bank rows = (bank<<8)|row per element -> 12 beats back-to-back from cycle start+2,
//   banks 0,0,0,0,1..2, out_last only on beat 11, done 1 cycle after beat 11.
//  N=3, out_ready toggles 1,0,0,1 pattern -> 9 beats, data held stable across stalls, no beat lost/duplicated.
//  N=0 -> no re asserted, out_valid never high, busy 1 for 2 cycles, done pulse once.
//  N=64 (max) -> raddr 0..63 per bank, 192 beats, no wrap to bank 3; second start during busy ignored.

Source files
------------

// File: rtl/tpu_result_reader.sv
// Drains result SRAM banks a, b, c (rows 0..num_rows-1 each) onto a valid/ready stream; first beat 2 cycles after start accept.
// Backpressure: reads are issued only while buffer + in-flight stays under 2, so a stalled consumer freezes the head beat.
module tpu_result_reader #(
  parameter int ARRAY_SIZE        = 8,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int SRAM_ADDR_WIDTH   = 6,
  parameter int BUF_DEPTH         = 2
) (
  input  logic                                      clk,
  input  logic                                      srstn,
  input  logic                                      start,
  input  logic [SRAM_ADDR_WIDTH:0]                  num_rows,
  output logic                                      sram_re_a,
  output logic                                      sram_re_b,
  output logic                                      sram_re_c,
  output logic [SRAM_ADDR_WIDTH-1:0]                sram_raddr_a,
  output logic [SRAM_ADDR_WIDTH-1:0]                sram_raddr_b,
  output logic [SRAM_ADDR_WIDTH-1:0]                sram_raddr_c,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_a,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_b,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_c,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   out_data,
  output logic [1:0]                                out_bank,
  output logic                                      out_last,
  output logic                                      busy,
  output logic                                      done
);

  localparam int RW = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int AW = SRAM_ADDR_WIDTH;
  localparam logic [AW:0] ROW_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state;
  logic [AW:0]   rows_q;
  logic [AW:0]   row;
  logic [1:0]    bank;
  logic          drain_hold;
  logic          inflight;
  logic          inflight_last;
  logic [1:0]    inflight_bank;
  logic [AW-1:0] raddr_a_q, raddr_b_q, raddr_c_q;

  logic [RW-1:0] buf_data [2];
  logic [1:0]    buf_bank [2];
  logic [1:0]    buf_last;
  logic          head;
  logic [1:0]    count;

  logic          pop, issue, row_end, last_issue, drain_exit, wr_idx;
  logic [2:0]    occupancy;
  logic [1:0]    post_pop;
  logic [RW-1:0] cap_data;

  assign pop        = out_valid && out_ready;
  assign occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == S_RUN) && (occupancy < 3'd2);
  assign row_end    = (row == rows_q - ROW_ONE);
  assign last_issue = issue && (bank == 2'd2) && row_end;
  assign post_pop   = count - {1'b0, pop};
  assign drain_exit = (state == S_DRAIN) && !drain_hold && !inflight && (post_pop == 2'd0);

  assign sram_re_a    = issue && (bank == 2'd0);
  assign sram_re_b    = issue && (bank == 2'd1);
  assign sram_re_c    = issue && (bank == 2'd2);
  assign sram_raddr_a = sram_re_a ? row[AW-1:0] : raddr_a_q;
  assign sram_raddr_b = sram_re_b ? row[AW-1:0] : raddr_b_q;
  assign sram_raddr_c = sram_re_c ? row[AW-1:0] : raddr_c_q;

  always_comb begin
    cap_data = sram_rdata_a;
    case (inflight_bank)
      2'd1:    cap_data = sram_rdata_b;
      2'd2:    cap_data = sram_rdata_c;
      default: cap_data = sram_rdata_a;
    endcase
  end

  assign wr_idx    = head ^ count[0];
  assign out_valid = (count != 2'd0);
  assign out_data  = buf_data[head];
  assign out_bank  = buf_bank[head];
  assign out_last  = buf_last[head];
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state         <= S_IDLE;
      rows_q        <= '0;
      row           <= '0;
      bank          <= 2'd0;
      drain_hold    <= 1'b0;
      inflight      <= 1'b0;
      inflight_bank <= 2'd0;
      inflight_last <= 1'b0;
      raddr_a_q     <= '0;
      raddr_b_q     <= '0;
      raddr_c_q     <= '0;
      done          <= 1'b0;
    end else begin
      done          <= drain_exit;
      inflight      <= issue;
      inflight_bank <= bank;
      inflight_last <= last_issue;
      if (sram_re_a) raddr_a_q <= row[AW-1:0];
      if (sram_re_b) raddr_b_q <= row[AW-1:0];
      if (sram_re_c) raddr_c_q <= row[AW-1:0];
      case (state)
        S_IDLE: begin
          if (start) begin
            rows_q <= num_rows;
            row    <= '0;
            bank   <= 2'd0;
            // Zero-row job still spends two cycles busy before done.
            if (num_rows == '0) begin
              state      <= S_DRAIN;
              drain_hold <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            if (row_end) begin
              row <= '0;
              if (bank == 2'd2) state <= S_DRAIN;
              else              bank  <= bank + 2'd1;
            end else begin
              row <= row + ROW_ONE;
            end
          end
        end
        S_DRAIN: begin
          drain_hold <= 1'b0;
          if (drain_exit) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      head     <= 1'b0;
      count    <= 2'd0;
      buf_last <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_bank[i] <= 2'd0;
      end
    end else begin
      if (inflight) begin
        buf_data[wr_idx] <= cap_data;
        buf_bank[wr_idx] <= inflight_bank;
        buf_last[wr_idx] <= inflight_last;
      end
      if (pop) head <= ~head;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // The issue credit check must make a capture into a full, unpopped buffer impossible.
  assert property (@(posedge clk) disable iff (!srstn)
    !(inflight && !pop && (count == 2'(BUF_DEPTH))));

endmodule

// File: tb/tb_tpu_result_reader.sv
// Self-checking bench for tpu_result_reader: SRAM model, beat-order queue model, random data and backpressure.
module tb_tpu_result_reader;
  localparam int AW = 6;
  localparam int RW = 128;

  logic          clk = 1'b0;
  logic          srstn, start, out_ready;
  logic [AW:0]   num_rows;
  logic          sram_re_a, sram_re_b, sram_re_c;
  logic [AW-1:0] sram_raddr_a, sram_raddr_b, sram_raddr_c;
  logic [RW-1:0] sram_rdata_a, sram_rdata_b, sram_rdata_c;
  logic          out_valid, out_last, busy, done;
  logic [RW-1:0] out_data;
  logic [1:0]    out_bank;

  logic [RW-1:0] mem [3][64];
  int reads = 0;
  int multi_re = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tpu_result_reader #(.ARRAY_SIZE(8), .OUTPUT_DATA_WIDTH(16), .SRAM_ADDR_WIDTH(AW), .BUF_DEPTH(2)) dut (
    .clk(clk), .srstn(srstn), .start(start), .num_rows(num_rows),
    .sram_re_a(sram_re_a), .sram_re_b(sram_re_b), .sram_re_c(sram_re_c),
    .sram_raddr_a(sram_raddr_a), .sram_raddr_b(sram_raddr_b), .sram_raddr_c(sram_raddr_c),
    .sram_rdata_a(sram_rdata_a), .sram_rdata_b(sram_rdata_b), .sram_rdata_c(sram_rdata_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_bank(out_bank),
    .out_last(out_last), .busy(busy), .done(done)
  );

  // Result SRAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (sram_re_a) sram_rdata_a <= mem[0][sram_raddr_a];
    if (sram_re_b) sram_rdata_b <= mem[1][sram_raddr_b];
    if (sram_re_c) sram_rdata_c <= mem[2][sram_raddr_c];
  end

  always @(posedge clk) begin
    if (srstn) begin
      reads <= reads + (sram_re_a ? 1 : 0) + (sram_re_b ? 1 : 0) + (sram_re_c ? 1 : 0);
      if ((sram_re_a && sram_re_b) || (sram_re_a && sram_re_c) || (sram_re_b && sram_re_c))
        multi_re <= multi_re + 1;
    end
  end

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input bit pattern);
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < 64; r++)
        if (pattern) mem[b][r] = {8{16'((b << 8) | r)}};
        else         mem[b][r] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  function automatic logic [154:0] idle_outputs();
    return {out_valid, out_data, out_bank, out_last, busy, done,
            sram_re_a, sram_re_b, sram_re_c, sram_raddr_a, sram_raddr_b, sram_raddr_c};
  endfunction

  // mode 0: ready always, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run_job(input int n, input int mode, input int restart_cyc);
    logic [130:0] expq [$];
    logic [130:0] held, beat;
    int c, beats, first_cyc, last_cyc, done_cnt, done_cyc, busy_cyc, reads0;
    bit stall;
    expq.delete();
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < n; r++)
        expq.push_back({mem[b][r], 2'(b), (b == 2) && (r == n - 1)});
    beats = 0; first_cyc = -1; last_cyc = -1; done_cnt = 0; done_cyc = -1;
    busy_cyc = 0; stall = 1'b0; held = '0;
    @(negedge clk);
    reads0 = reads;
    start = 1'b1;
    num_rows = (AW+1)'(n);
    out_ready = 1'b0;
    c = 0;
    while (c < 2000 && !(done_cnt > 0 && c > done_cyc + 3)) begin
      @(negedge clk);
      c++;
      start = (c == restart_cyc);
      if (c == restart_cyc) num_rows = (AW+1)'(1);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      beat = {out_data, out_bank, out_last};
      if (stall) chk("hold_stable", {out_valid, beat}, {1'b1, held});
      stall = out_valid && !out_ready;
      held = beat;
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (out_valid && out_ready) begin
        beats++;
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        if (expq.size() != 0) chk("beat", beat, expq.pop_front());
      end
    end
    start = 1'b0;
    chk("beat_count", beats, 3 * n);
    chk("done_pulses", done_cnt, 1);
    chk("sram_reads", reads - reads0, 3 * n);
    chk("one_hot_re", multi_re, 0);
    chk("busy_cycles", busy_cyc, done_cyc - 1);
    chk("busy_after_done", busy, 0);
    if (n > 0) chk("done_after_last", done_cyc, last_cyc + 1);
    else       chk("done_zero_rows", done_cyc, 3);
    if (mode == 0 && n > 0) begin
      chk("first_valid_cyc", first_cyc, 3);
      chk("last_beat_cyc", last_cyc, 3 * n + 2);
    end
  endtask

  initial begin
    bit found;
    srstn = 1'b0; start = 1'b0; num_rows = '0; out_ready = 1'b0;
    #12;
    chk("reset_outputs", idle_outputs(), '0);
    @(negedge clk) srstn = 1'b1;

    // Abort during bank b, then a fresh job must start from a[0].
    fill(1'b0);
    @(negedge clk);
    start = 1'b1; num_rows = (AW+1)'(5); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (out_valid && out_bank == 2'd1) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_bank_b", found, 1);
    srstn = 1'b0;
    #1;
    chk("midrun_reset_outputs", idle_outputs(), '0);
    @(negedge clk) srstn = 1'b1;
    run_job(2, 0, -1);

    fill(1'b1);
    run_job(4, 0, -1);
    fill(1'b0);
    run_job(3, 1, -1);
    run_job(0, 0, -1);
    run_job(64, 0, 20);
    for (int k = 0; k < 3; k++) begin
      fill(1'b0);
      run_job($urandom_range(1, 12), 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
